// File: rtl/fifo_unpacker_pkg.sv
// Shared types and helpers for the fifo word unpacker (and a future packer).
package fifo_unpacker_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } unpack_state_t;

  // Widest word the slice helper can handle; callers zero-extend into it.
  localparam int unsigned SLICE_MAX_W = 1024;

  // Returns the word shifted so that beat 'idx' sits in the low out_w bits.
  // msb_first selects whether beat 0 is the top or the bottom slice.
  function automatic logic [SLICE_MAX_W-1:0] slice_sel(
    input logic [SLICE_MAX_W-1:0] word,
    input int unsigned            idx,
    input int unsigned            out_w,
    input int unsigned            ratio,
    input logic                   msb_first
  );
    int unsigned pos;
    if (msb_first) begin
      pos = ratio - 32'd1 - idx;
    end else begin
      pos = idx;
    end
    return word >> (pos * out_w);
  endfunction

endpackage

// File: rtl/fifo_unpacker_word_slice_mux.sv
// Combinational beat selector: picks slice idx of a held word, zero when invalid.
module word_slice_mux
  import fifo_unpacker_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned RATIO     = 4,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic                       valid_i,
  input  logic [DATA_W-1:0]          word_i,
  input  logic [$clog2(RATIO)-1:0]   idx_i,
  output logic [DATA_W/RATIO-1:0]    data_o
);

  localparam int unsigned OUT_W = DATA_W / RATIO;

  // Select the current beat; force zero so idle output never leaks stale data.
  always_comb begin
    if (valid_i) begin
      data_o = OUT_W'(slice_sel(SLICE_MAX_W'(word_i), 32'(idx_i), OUT_W, RATIO, MSB_FIRST));
    end else begin
      data_o = '0;
    end
  end

endmodule

// File: rtl/fifo_unpacker.sv
// Pops wide words from a FWFT fifo and emits each as RATIO narrow beats on a
// valid/ready stream, reloading the next word in the cycle the last beat goes.
module fifo_unpacker
  import fifo_unpacker_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned RATIO     = 4,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    f_empty_i,
  input  logic [DATA_W-1:0]       f_data_i,
  output logic                    f_req_o,
  input  logic                    flush_i,
  output logic                    out_valid_o,
  output logic [DATA_W/RATIO-1:0] out_data_o,
  output logic                    out_last_o,
  input  logic                    out_ready_i,
  output logic                    busy_o
);

  localparam int unsigned IDX_W    = $clog2(RATIO);
  localparam int unsigned LAST_IDX = RATIO - 32'd1;

  // Reject configurations the beat indexing cannot represent.
  if ((RATIO < 32'd2) || ((RATIO & (RATIO - 32'd1)) != 32'd0) ||
      ((DATA_W % RATIO) != 32'd0) || (DATA_W > SLICE_MAX_W)) begin : g_bad_cfg
    $error("fifo_unpacker: RATIO must be a power of 2 >= 2 dividing DATA_W");
  end

  unpack_state_t      state_q;
  logic [IDX_W-1:0]   idx_q;
  logic [DATA_W-1:0]  word_q;

  logic valid_s;
  logic last_beat_s;
  logic take_s;
  logic last_take_s;
  logic f_req_s;

  // Handshake decode; the pop is gated so it can never hit an empty fifo.
  always_comb begin
    valid_s     = (state_q == S_HOLD);
    last_beat_s = valid_s && (idx_q == IDX_W'(LAST_IDX));
    take_s      = valid_s && out_ready_i;
    last_take_s = take_s && last_beat_s;
    f_req_s     = !rst && !flush_i && !f_empty_i && ((state_q == S_IDLE) || last_take_s);
  end

  // Word/beat-index FSM: reload on pop, step on accept, idle when drained.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      word_q  <= '0;
    end else if (f_req_s) begin
      state_q <= S_HOLD;
      idx_q   <= '0;
      word_q  <= f_data_i;
    end else begin
      case (state_q)
        S_HOLD: begin
          if (take_s) begin
            if (last_beat_s) begin
              state_q <= S_IDLE;
            end else begin
              idx_q <= idx_q + IDX_W'(1'b1);
            end
          end
        end
        default: begin
          state_q <= state_q;
        end
      endcase
    end
  end

  word_slice_mux #(
    .DATA_W   (DATA_W),
    .RATIO    (RATIO),
    .MSB_FIRST(MSB_FIRST)
  ) u_slice_mux (
    .valid_i(valid_s),
    .word_i (word_q),
    .idx_i  (idx_q),
    .data_o (out_data_o)
  );

  assign f_req_o     = f_req_s;
  assign out_valid_o = valid_s;
  assign out_last_o  = last_beat_s;
  assign busy_o      = valid_s;

endmodule
